// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and the bit-period helper.
// Used by both the receiver and the companion transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Receiver-side bundle: serial line in, byte and strobes out.
// slave = the receiver, master = the consumer that owns the line.
interface uart_rx_8n1_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line, preset to idle-high, plus a
// registered copy of the synchronised value used for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s      = r_sync;
  assign o_fall_edge = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: start-bit validation, mid-bit sampling, framing check.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_8n1_if.slave  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_fall_edge;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (bus.rx),
    .o_rx_s      (w_rx_s),
    .o_fall_edge (w_fall_edge)
  );

  uart_state_t          r_state,     w_state_next;
  logic [CNT_W-1:0]     r_cnt,       w_cnt_next;
  logic [IDX_W-1:0]     r_bit_idx,   w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shreg,     w_shreg_next;
  logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_next;
  logic                 r_rx_valid,  w_rx_valid_next;
  logic                 r_frame_err, w_frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit,    w_par_bit_next;
  logic                 r_parity_err, w_parity_err_next;
  logic                 w_par_bad;

  // Even parity over data plus parity bit must come out zero.
  assign w_par_bad = ^{r_shreg, r_par_bit};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shreg     <= w_shreg_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_frame_err <= w_frame_err_next;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= w_par_bit_next;
      r_parity_err <= w_parity_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + 1'b1;
    w_bit_idx_next   = r_bit_idx;
    w_shreg_next     = r_shreg;
    w_rx_data_next   = r_rx_data;
    w_rx_valid_next  = 1'b0;
    w_frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_next    = r_par_bit;
    w_parity_err_next = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        // Edge-triggered, so a line held low (break) never restarts a frame.
        if (w_fall_edge) w_state_next = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_state_next = IDLE;
          end else begin
            w_state_next   = DATA;
            w_bit_idx_next = '0;
          end
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next     = '0;
          w_shreg_next   = {w_rx_s, r_shreg[DATA_BITS-1:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next     = '0;
          w_par_bit_next = w_rx_s;
          w_state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          // Leave mid-stop-bit so an immediately following start edge is seen.
          w_cnt_next       = '0;
          w_state_next     = IDLE;
          w_frame_err_next = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
          w_parity_err_next = w_par_bad;
          w_rx_valid_next   = w_rx_s & ~w_par_bad;
`else
          w_rx_valid_next   = w_rx_s;
`endif
          if (w_rx_valid_next) w_rx_data_next = r_shreg;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at 16 clocks per bit: table of single frames plus
// glitch, back-to-back and mid-frame reset sequences. Honours UART_RX_PARITY_EN.
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT = 2 + HALF + (NBITS - 1) * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: cycle counter and strobe bookkeeping.
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0, n_overlap = 0, valid_cyc = 0;
  logic busy_prev = 1'b0, busy_at_valid = 1'b0, busy_before_valid = 1'b0;
  logic [7:0] valid_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_prev <= bus.busy;
    if (bus.busy) n_busy <= n_busy + 1;
    if (bus.frame_err) n_ferr <= n_ferr + 1;
    if (bus.parity_err) n_perr <= n_perr + 1;
    if (bus.rx_valid && (bus.frame_err || bus.parity_err)) n_overlap <= n_overlap + 1;
    if (bus.rx_valid) begin
      n_valid           <= n_valid + 1;
      valid_cyc         <= cyc;
      busy_at_valid     <= bus.busy;
      busy_before_valid <= busy_prev;
      valid_q.push_back(bus.rx_data);
    end
  end

  int checks = 0;
  int failures = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    fall_cyc = cyc;
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par;
    repeat (CPB) @(negedge clk);
`else
    if (par !== 1'b0 && par !== 1'b1) $display("note: parity arg unused");
`endif
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];
  int   n_vec;
  int   b_valid, b_ferr, b_perr, b_busy, b_q;
  int   lat;

  initial begin
    // data, parity(even), stop, valid, ferr, perr, rx_data afterwards
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80};
    n_vec = 5;
`ifdef UART_RX_PARITY_EN
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
    vecs[6] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07};
    vecs[7] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};
    n_vec = 8;
`endif

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_data", int'(bus.rx_data), 0);
    check("reset rx_valid", int'(bus.rx_valid), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    check("reset parity_err", int'(bus.parity_err), 0);
    check("reset busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < n_vec; i++) begin
      b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d valid", i), n_valid - b_valid, int'(vecs[i].exp_valid));
      check($sformatf("vec%0d frame_err", i), n_ferr - b_ferr, int'(vecs[i].exp_ferr));
      check($sformatf("vec%0d parity_err", i), n_perr - b_perr, int'(vecs[i].exp_perr));
      check($sformatf("vec%0d rx_data", i), int'(bus.rx_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d busy idle", i), int'(bus.busy), 0);
      if (vecs[i].exp_valid) begin
        lat = valid_cyc - fall_cyc;
        check($sformatf("vec%0d latency in window", i),
              int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        check($sformatf("vec%0d busy before valid", i), int'(busy_before_valid), 1);
        check($sformatf("vec%0d busy at valid", i), int'(busy_at_valid), 0);
      end
    end

    // Short low glitch: rejected at the start-bit midpoint.
    b_valid = n_valid; b_ferr = n_ferr; b_busy = n_busy;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch valid", n_valid - b_valid, 0);
    check("glitch frame_err", n_ferr - b_ferr, 0);
    check("glitch busy seen", int'((n_busy - b_busy) > 0), 1);
    check("glitch busy bounded", int'((n_busy - b_busy) <= HALF + 3), 1);
    check("glitch busy idle", int'(bus.busy), 0);

    // Back-to-back frames: next start bit directly follows the stop bit.
    b_valid = n_valid; b_q = valid_q.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b valid count", n_valid - b_valid, 2);
    check("b2b first", (valid_q.size() > b_q) ? int'(valid_q[b_q]) : -1, 8'h00);
    check("b2b second", (valid_q.size() > b_q + 1) ? int'(valid_q[b_q + 1]) : -1, 8'hFF);

    // Reset during bit 4 of 0x55, then a clean 0x81.
    b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr;
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i % 2 == 0);
      repeat (CPB) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst rx_data", int'(bus.rx_data), 0);
    check("midrst rx_valid", int'(bus.rx_valid), 0);
    check("midrst busy", int'(bus.busy), 0);
    check("midrst frame_err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst no strobe", (n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr), 0);
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("after rst valid", n_valid - b_valid, 1);
    check("after rst rx_data", int'(bus.rx_data), 8'h81);
    check("after rst frame_err", n_ferr - b_ferr, 0);

    check("valid never with error", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
